adder_err_monitor: RTL and testbench
====================================

# adder_err_monitor

Pipelined error monitor that sits directly downstream of a generated approximate 2-operand adder. It consumes each operand pair together with the approximate sum, computes the exact sum and the absolute error, and checks it against the error threshold. It accumulates running statistics for on-line quality assessment of the approximated circuit: sample count, violation count, maximum error and error sum.

## Interface
Parameters:
- `W`, 2, operand width; adder inputs map as a = {in1,in0}, b = {in3,in2}
- `ET`, 2, error threshold; a sample is a violation when |err| > ET
- `CNT_W`, 16, width of sample and violation counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous clear of statistics and pipeline
- `in_valid`  in  1  sample present
- `in_ready`  out  1  block can accept a sample
- `in_a`  in  W  operand a
- `in_b`  in  W  operand b
- `in_approx`  in  W+1  approximate sum, {out2,out1,out0} for W=2
- `sample_cnt`  out  CNT_W  retired samples
- `viol_cnt`  out  CNT_W  retired violations
- `max_err`  out  W+1  largest |err| retired
- `err_sum`  out  CNT_W+W+1  sum of |err|; cannot overflow
- `viol_pulse`  out  1  one-cycle pulse per retired violation
- `last_viol`  out  3W+1  {a,b,approx} of most recent violation
- `done`  out  1  block is in FROZEN state

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`; `in_valid` is ignored when `in_ready` is low.
- The pipeline has three stages:
  - S1 registers a, b and approx with a valid bit.
  - S2 computes exact = a+b (W+1 bits, unsigned) and err = |approx − exact| (W+1 bits), and registers err and the viol bit.
  - S3 updates the accumulators.
- At S3 retire:
  - `sample_cnt` increments by 1.
  - `err_sum` increases by err.
  - `max_err` becomes max(max_err, err).
  - On a violation, `viol_cnt` increments, `last_viol` is loaded and `viol_pulse` is asserted.
- An internal accept counter `acc_cnt` (CNT_W bits) counts transfers.
- States are RUN, DRAIN and FROZEN; reset state is RUN.
  - RUN → DRAIN on the transfer that makes `acc_cnt` = 2^CNT_W−1.
  - DRAIN → FROZEN when S1 and S2 are both empty.
  - FROZEN → RUN only on `clear`.
- `in_ready` = (state == RUN) && !clear.
- `clear` overrides everything else:
  - Zeroes all statistics, `acc_cnt`, `last_viol` and the pipeline valid bits.
  - Discards in-flight samples.
  - Forces state to RUN on the next edge.
  - A transfer cannot occur in the same cycle as `clear`.
- No accumulator wraps. `viol_cnt` ≤ `sample_cnt` always.

## Timing
- All outputs reset to 0 asynchronously on `rst_n` low: counters, `max_err`, `err_sum`, `viol_pulse`, `last_viol` and `done`. `in_ready` is 1 once `rst_n` is high.
- Latency: a sample transferred at edge k is reflected in the statistics and `viol_pulse` after edge k+2.
- Back-to-back throughput is one sample per cycle; no bubbles are required.
- `viol_pulse` is high for exactly one cycle per violation; consecutive violations produce consecutive high cycles.
- `done` rises on the edge entering FROZEN, and only after the last accepted sample has retired.
- If `rst_n` is asserted mid-operation, pipeline contents are lost and no partial update occurs.

## Configuration
- Macro `ERR_MON_HIST_EN`.
- Defined:
  - Adds output `err_hist`, 2^(W+1) bins × CNT_W bits, flattened.
  - Bin e increments at retire of a sample with err = e.
  - Bins are cleared by reset and by `clear`.
  - Sum of bins equals `sample_cnt`.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Structure
- Package `adder_err_pkg` holds:
  - The state enum {RUN, DRAIN, FROZEN}.
  - Width helper constants derived from W and CNT_W.
  - A packed struct for a pipeline entry {a, b, approx, err, viol, valid}.
- One sub-module, `adder_err_calc`:
  - Combinational; takes a, b and approx.
  - Produces exact, err and viol.
  - Parameterised by W and ET; instanced in S2.

## Test plan
- Reset: with `rst_n` low, mid-stream, all outputs are 0. After release, `in_ready` = 1.
- Single sample: a=3, b=3, approx=2 → after edge k+2, `sample_cnt` = 1, `viol_cnt` = 1, `max_err` = 4, `err_sum` = 4, one `viol_pulse`, `last_viol` = {3,3,2}.
- Exact results: a=1, b=2, approx=3, then a=2, b=2, approx=4 → `sample_cnt` = 2, `viol_cnt` = 0, `max_err` = 0.
- Threshold boundary: a=0, b=2, approx=4 → err = 2, no violation. Then a=0, b=1, approx=4 → err = 3, violation.
- Saturation with CNT_W=3:
  - Stream 7 samples back-to-back; `in_ready` drops after the 7th transfer.
  - `done` rises 2 cycles later with `sample_cnt` = 7.
  - Further `in_valid` is ignored.
  - `clear` returns to RUN with all statistics at 0.
- Clear mid-flight: issue `clear` with S1 and S2 full → the in-flight samples never retire, no `viol_pulse` is generated, and all statistics are 0. With `ERR_MON_HIST_EN` defined, all bins are 0.

Source files
------------

// File: rtl/adder_err_monitor_pkg.sv
// ============================================================================
//  Module   : adder_err_pkg
//  Purpose  : Shared types and width helpers for the adder error monitor.
//             Holds the FSM state enum, the S2 pipeline entry and default
//             widths. The pipeline entry is sized from OP_W, so the monitor
//             must be built with W == OP_W.
//  Options  : ERR_MON_HIST_EN (adds an |err| histogram output)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_err_pkg;

    localparam int OP_W      = 2;
    localparam int DEF_ET    = 2;
    localparam int DEF_CNT_W = 16;
    localparam int SUM_W     = OP_W + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [SUM_W-1:0] approx;
        logic [SUM_W-1:0] err;
        logic             viol;
        logic             valid;
    } pipe_entry_t;

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    // Wide enough for (2^cnt_w - 1) samples of the largest |err|.
    function automatic int err_sum_w(input int w, input int cnt_w);
        return cnt_w + w + 1;
    endfunction

    function automatic int viol_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int hist_bins(input int w);
        return 1 << (w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_err_monitor_if.sv
// ============================================================================
//  Module   : adder_err_monitor_if
//  Purpose  : Sample handshake and statistics bus of the adder error monitor.
//             master = sample source / statistics reader, slave = monitor.
//  Options  : ERR_MON_HIST_EN (adds err_hist)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_err_monitor_if
    import adder_err_pkg::*;
#(
    parameter int W     = OP_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic                            clear;
    logic                            in_valid;
    logic                            in_ready;
    logic [W-1:0]                    in_a;
    logic [W-1:0]                    in_b;
    logic [sum_w(W)-1:0]             in_approx;
    logic [CNT_W-1:0]                sample_cnt;
    logic [CNT_W-1:0]                viol_cnt;
    logic [sum_w(W)-1:0]             max_err;
    logic [err_sum_w(W, CNT_W)-1:0]  err_sum;
    logic                            viol_pulse;
    logic [viol_w(W)-1:0]            last_viol;
    logic                            done;
`ifdef ERR_MON_HIST_EN
    logic [hist_bins(W)*CNT_W-1:0]   err_hist;

    modport master (
        output clear, in_valid, in_a, in_b, in_approx,
        input  in_ready, sample_cnt, viol_cnt, max_err, err_sum,
               viol_pulse, last_viol, done, err_hist
    );
    modport slave (
        input  clear, in_valid, in_a, in_b, in_approx,
        output in_ready, sample_cnt, viol_cnt, max_err, err_sum,
               viol_pulse, last_viol, done, err_hist
    );
`else
    modport master (
        output clear, in_valid, in_a, in_b, in_approx,
        input  in_ready, sample_cnt, viol_cnt, max_err, err_sum,
               viol_pulse, last_viol, done
    );
    modport slave (
        input  clear, in_valid, in_a, in_b, in_approx,
        output in_ready, sample_cnt, viol_cnt, max_err, err_sum,
               viol_pulse, last_viol, done
    );
`endif

endinterface

`default_nettype wire

// File: rtl/adder_err_monitor_calc.sv
// ============================================================================
//  Module   : adder_err_calc
//  Purpose  : Combinational exact sum, absolute error and threshold check
//             for one operand pair and its approximate sum.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_err_calc #(
    parameter int W  = 2,
    parameter int ET = 2
) (
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    input  wire logic [W:0]   approx_i,
    output logic      [W:0]   exact_o,
    output logic      [W:0]   err_o,
    output logic              viol_o
);
    localparam logic [W:0] C_ET = (W + 1)'(ET);

    // Exact sum is one bit wider than the operands, so it cannot overflow.
    always_comb begin
        exact_o = {1'b0, a_i} + {1'b0, b_i};
        if (approx_i >= exact_o) begin
            err_o = approx_i - exact_o;
        end else begin
            err_o = exact_o - approx_i;
        end
        viol_o = (err_o > C_ET);
    end

endmodule

`default_nettype wire

// File: rtl/adder_err_monitor.sv
// ============================================================================
//  Module   : adder_err_monitor
//  Purpose  : Three-stage error monitor for an approximate 2-operand adder.
//             S1 captures the sample, S2 computes |err| and the violation
//             flag, S3 retires into the running statistics. After
//             2^CNT_W-1 accepted samples the block drains and freezes until
//             a clear, so no statistic can wrap.
//  Options  : ERR_MON_HIST_EN (adds err_hist, one CNT_W counter per |err|)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_err_monitor
    import adder_err_pkg::*;
#(
    parameter int W     = OP_W,
    parameter int ET    = DEF_ET,
    parameter int CNT_W = DEF_CNT_W
) (
    input wire logic           clk,
    input wire logic           rst_n,
    adder_err_monitor_if.slave bus
);
    localparam int               C_SUM_W  = sum_w(W);
    localparam int               C_ESUM_W = err_sum_w(W, CNT_W);
    localparam int               C_VIOL_W = viol_w(W);
    localparam logic [CNT_W-1:0] C_ACC_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_e               state_q;
    logic [CNT_W-1:0]     acc_cnt_q;
    logic                 done_q;

    logic                 s1_valid_q;
    logic [W-1:0]         s1_a_q;
    logic [W-1:0]         s1_b_q;
    logic [C_SUM_W-1:0]   s1_approx_q;

    pipe_entry_t          s2_d;
    pipe_entry_t          s2_q;
    logic [C_SUM_W-1:0]   w_exact_unused;
    logic [C_SUM_W-1:0]   w_err;
    logic                 w_viol;

    logic [CNT_W-1:0]     sample_cnt_q;
    logic [CNT_W-1:0]     viol_cnt_q;
    logic [C_SUM_W-1:0]   max_err_q;
    logic [C_ESUM_W-1:0]  err_sum_q;
    logic                 viol_pulse_q;
    logic [C_VIOL_W-1:0]  last_viol_q;

    logic                 w_xfer;

    assign bus.in_ready = (state_q == RUN) && !bus.clear;
    assign w_xfer       = bus.in_valid && bus.in_ready;

    // Acceptance FSM: stop accepting at the last countable sample, then
    // freeze once nothing remains ahead of S3. In DRAIN S1 never refills,
    // so an empty S1 means S2 holds at most the final sample, which
    // retires on the same edge that enters FROZEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            acc_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (bus.clear) begin
            state_q   <= RUN;
            acc_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_xfer) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                        if (acc_cnt_q == C_ACC_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid_q) begin
                        state_q <= FROZEN;
                        done_q  <= 1'b1;
                    end
                end
                FROZEN: begin
                    state_q <= FROZEN;
                end
                default: begin
                    state_q <= RUN;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // S1: capture the transferred sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_approx_q <= '0;
        end else if (bus.clear) begin
            s1_valid_q  <= 1'b0;
        end else begin
            s1_valid_q <= w_xfer;
            if (w_xfer) begin
                s1_a_q      <= bus.in_a;
                s1_b_q      <= bus.in_b;
                s1_approx_q <= bus.in_approx;
            end
        end
    end

    adder_err_calc #(
        .W  (W),
        .ET (ET)
    ) u_calc (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .approx_i (s1_approx_q),
        .exact_o  (w_exact_unused),
        .err_o    (w_err),
        .viol_o   (w_viol)
    );

    // Assemble the S2 entry from S1 and the error calculation.
    always_comb begin
        s2_d        = '0;
        s2_d.a      = s1_a_q;
        s2_d.b      = s1_b_q;
        s2_d.approx = s1_approx_q;
        s2_d.err    = w_err;
        s2_d.viol   = w_viol;
        s2_d.valid  = s1_valid_q;
    end

    // S2: register error and violation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (bus.clear) begin
            s2_q <= '0;
        end else begin
            s2_q <= s2_d;
        end
    end

    // S3: retire the S2 entry into the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
            err_sum_q    <= '0;
            viol_pulse_q <= 1'b0;
            last_viol_q  <= '0;
        end else if (bus.clear) begin
            sample_cnt_q <= '0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
            err_sum_q    <= '0;
            viol_pulse_q <= 1'b0;
            last_viol_q  <= '0;
        end else begin
            viol_pulse_q <= s2_q.valid && s2_q.viol;
            if (s2_q.valid) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                err_sum_q    <= err_sum_q + C_ESUM_W'(s2_q.err);
                if (s2_q.err > max_err_q) begin
                    max_err_q <= s2_q.err;
                end
                if (s2_q.viol) begin
                    viol_cnt_q  <= viol_cnt_q + CNT_W'(1);
                    last_viol_q <= {s2_q.a, s2_q.b, s2_q.approx};
                end
            end
        end
    end

    assign bus.sample_cnt = sample_cnt_q;
    assign bus.viol_cnt   = viol_cnt_q;
    assign bus.max_err    = max_err_q;
    assign bus.err_sum    = err_sum_q;
    assign bus.viol_pulse = viol_pulse_q;
    assign bus.last_viol  = last_viol_q;
    assign bus.done       = done_q;

`ifdef ERR_MON_HIST_EN
    localparam int C_BINS = hist_bins(W);

    logic [CNT_W-1:0] hist_q [C_BINS];

    // One counter per possible |err| value, bumped at S3 retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_BINS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < C_BINS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (s2_q.valid) begin
            hist_q[s2_q.err] <= hist_q[s2_q.err] + CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < C_BINS; gi++) begin : g_hist_bin
        assign bus.err_hist[gi*CNT_W +: CNT_W] = hist_q[gi];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_err_monitor.sv
// ============================================================================
//  Module   : tb_adder_err_monitor
//  Purpose  : Self-checking bench for adder_err_monitor (W=2, ET=2,
//             CNT_W=3). A queue-based reference model retires each accepted
//             sample two edges after acceptance.
//  Options  : ERR_MON_HIST_EN (histogram bins are also compared)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_err_monitor;

    localparam int W       = 2;
    localparam int ET      = 2;
    localparam int CNT_W   = 3;
    localparam int MAX_ACC = (1 << CNT_W) - 1;
    localparam int NBINS   = 1 << (W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    adder_err_monitor_if #(.W(W), .CNT_W(CNT_W)) bus ();

    adder_err_monitor #(
        .W     (W),
        .ET    (ET),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int a;
        int b;
        int ap;
        int ret;
    } smp_t;

    smp_t pend[$];
    int   cyc        = 0;
    int   m_acc      = 0;
    int   m_last_acc = 0;
    int   m_samples  = 0;
    int   m_viols    = 0;
    int   m_max      = 0;
    int   m_sum      = 0;
    int   m_pulse    = 0;
    int   m_last     = 0;
    int   m_hist [NBINS];

    function automatic int abs_err(input int a, input int b, input int ap);
        int ex;
        ex = a + b;
        return (ap >= ex) ? ap - ex : ex - ap;
    endfunction

    function automatic int m_done();
        return ((m_acc == MAX_ACC) && (cyc >= m_last_acc + 2)) ? 1 : 0;
    endfunction

    task automatic model_clear();
        pend.delete();
        m_acc     = 0;
        m_samples = 0;
        m_viols   = 0;
        m_max     = 0;
        m_sum     = 0;
        m_pulse   = 0;
        m_last    = 0;
        for (int i = 0; i < NBINS; i++) m_hist[i] = 0;
    endtask

    task automatic check_outputs();
        check("sample_cnt", bus.sample_cnt, m_samples);
        check("viol_cnt",   bus.viol_cnt,   m_viols);
        check("max_err",    bus.max_err,    m_max);
        check("err_sum",    bus.err_sum,    m_sum);
        check("viol_pulse", bus.viol_pulse, m_pulse);
        check("last_viol",  bus.last_viol,  m_last);
        check("done",       bus.done,       m_done());
`ifdef ERR_MON_HIST_EN
        for (int i = 0; i < NBINS; i++) begin
            check($sformatf("err_hist[%0d]", i), bus.err_hist[i*CNT_W +: CNT_W], m_hist[i]);
        end
`endif
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check stats.
    task automatic cycle(input bit v, input int a, input int b, input int ap, input bit clr);
        bit   rdy;
        int   e;
        smp_t s;
        bus.in_valid  = v;
        bus.in_a      = a[W-1:0];
        bus.in_b      = b[W-1:0];
        bus.in_approx = ap[W:0];
        bus.clear     = clr;
        #1;
        rdy = (m_acc < MAX_ACC) && !clr;
        check("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        cyc++;
        if (clr) begin
            model_clear();
        end else begin
            m_pulse = 0;
            while (pend.size() > 0 && pend[0].ret == cyc) begin
                s = pend.pop_front();
                e = abs_err(s.a, s.b, s.ap);
                m_samples++;
                m_sum += e;
                if (e > m_max) m_max = e;
                m_hist[e]++;
                if (e > ET) begin
                    m_viols++;
                    m_pulse = 1;
                    m_last  = (s.a << 5) | (s.b << 3) | s.ap;
                end
            end
            if (v && rdy) begin
                pend.push_back('{a, b, ap, cyc + 2});
                m_acc++;
                if (m_acc == MAX_ACC) m_last_acc = cyc;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 0, 0, 0, 1'b1);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst sample_cnt", bus.sample_cnt, 0);
        check("rst viol_cnt",   bus.viol_cnt,   0);
        check("rst max_err",    bus.max_err,    0);
        check("rst err_sum",    bus.err_sum,    0);
        check("rst viol_pulse", bus.viol_pulse, 0);
        check("rst last_viol",  bus.last_viol,  0);
        check("rst done",       bus.done,       0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_approx = '0;
        #1;
        do_reset();

        // Single violating sample.
        cycle(1'b1, 3, 3, 2, 1'b0);
        idle(3);
        check("single sample_cnt", bus.sample_cnt, 1);
        check("single viol_cnt",   bus.viol_cnt,   1);
        check("single max_err",    bus.max_err,    4);
        check("single err_sum",    bus.err_sum,    4);
        check("single last_viol",  bus.last_viol,  7'b11_11_010);
        do_clear();

        // Exact results.
        cycle(1'b1, 1, 2, 3, 1'b0);
        cycle(1'b1, 2, 2, 4, 1'b0);
        idle(3);
        check("exact sample_cnt", bus.sample_cnt, 2);
        check("exact viol_cnt",   bus.viol_cnt,   0);
        check("exact max_err",    bus.max_err,    0);
        do_clear();

        // Threshold boundary: err=2 passes, err=3 violates.
        cycle(1'b1, 0, 2, 4, 1'b0);
        cycle(1'b1, 0, 1, 4, 1'b0);
        idle(3);
        check("thresh viol_cnt",  bus.viol_cnt,  1);
        check("thresh max_err",   bus.max_err,   3);
        check("thresh err_sum",   bus.err_sum,   5);
        check("thresh last_viol", bus.last_viol, 7'b00_01_100);
        do_clear();

        // Saturation: seven back-to-back transfers, then ignored valids.
        for (int i = 0; i < MAX_ACC; i++) begin
            cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 3, 3, 0, 1'b0);
        check("sat done",       bus.done,       1);
        check("sat sample_cnt", bus.sample_cnt, 7);
        do_clear();
        check("sat clr sample_cnt", bus.sample_cnt, 0);
        check("sat clr done",       bus.done,       0);

        // Clear with S1 and S2 both holding violating samples.
        cycle(1'b1, 3, 3, 2, 1'b0);
        cycle(1'b1, 3, 3, 1, 1'b0);
        do_clear();
        idle(3);
        check("midclr sample_cnt", bus.sample_cnt, 0);
        check("midclr viol_cnt",   bus.viol_cnt,   0);
        check("midclr viol_pulse", bus.viol_pulse, 0);

        // Mid-stream reset.
        cycle(1'b1, 3, 0, 7, 1'b0);
        cycle(1'b1, 1, 1, 0, 1'b0);
        do_reset();
        idle(3);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                      ($urandom_range(0, 29) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
